// File: rtl/fp32_pkg.sv
// Shared fp32 constants, field widths and the divider state encoding.
package fp32_pkg;

    localparam int EXP_BIAS = 127;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    localparam int QBITS   = 26;
    localparam int LATENCY = 1 + QBITS + 1;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ITER,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/fp32_round_pack.sv
// Combinational normalize, round-to-nearest-even, range check and pack of a
// 26-bit quotient (1 integer + 23 fraction + guard + round) plus sticky.
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] e,
    input  logic [25:0]       q,
    input  logic              sticky,
    output logic [31:0]       out,
    output logic              overflow,
    output logic              underflow
);

    logic [25:0]        qn;
    logic signed [9:0]  en;
    logic signed [9:0]  er;
    logic [23:0]        mant;
    logic               guard;
    logic               rnd;
    logic               round_up;
    logic [24:0]        mant_r;
    logic [FRAC_W-1:0]  frac;

    always_comb begin
        qn = q;
        en = e;
        if (!q[25]) begin
            qn = {q[24:0], 1'b0};
            en = e - 10'sd1;
        end

        mant     = qn[25:2];
        guard    = qn[1];
        rnd      = qn[0];
        round_up = guard & (rnd | sticky | mant[0]);
        mant_r   = {1'b0, mant} + 25'(round_up);

        // A carry out of the rounded mantissa means it became exactly 2.0
        frac = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        er   = mant_r[24] ? (en + 10'sd1) : en;

        overflow  = 1'b0;
        underflow = 1'b0;
        out       = {sign, er[7:0], frac};
        if (er >= 10'sd255) begin
            out      = {sign, POS_INF[30:0]};
            overflow = 1'b1;
        end else if (er <= 10'sd0) begin
            out       = {sign, 31'd0};
            underflow = 1'b1;
        end
    end

endmodule

// File: rtl/fdiv_seq.sv
// Iterative fp32 divider (out = in1 / in2) using restoring radix-2 division,
// one quotient bit per cycle, with a fixed start-to-done latency.
module fdiv_seq
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic [3:0]  flags
);

    state_t state, state_nxt;

    logic [31:0]        a, b;
    logic [EXP_W-1:0]   ea, eb;
    logic [FRAC_W-1:0]  fa, fb;
    logic               a_nan, a_inf, a_zero;
    logic               b_nan, b_inf, b_zero;
    logic               sign;
    logic signed [9:0]  e;
    logic [23:0]        mb;
    logic               accept;

    logic               special;
    logic [31:0]        special_out;
    logic [3:0]         special_flags;

    logic [24:0]        rem, rem_sub;
    logic               qbit;
    logic [25:0]        q;
    logic [4:0]         cnt;
    logic               sticky;

    logic [31:0]        rp_out;
    logic               rp_of, rp_uf;

    // Operands stay latched for the whole operation, so unpacking is combinational
    assign ea     = a[FRAC_W +: EXP_W];
    assign eb     = b[FRAC_W +: EXP_W];
    assign fa     = a[FRAC_W-1:0];
    assign fb     = b[FRAC_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);
    assign sign   = a[31] ^ b[31];
    assign e      = $signed({2'b00, ea} - {2'b00, eb} + 10'(EXP_BIAS));
    assign mb     = {1'b1, fb};
    assign sticky = |rem;

    assign accept = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        special       = 1'b1;
        special_out   = QNAN;
        special_flags = 4'b0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_flags = 4'b1000;
        end else if (b_zero && !a_inf) begin
            special_out   = {sign, POS_INF[30:0]};
            special_flags = 4'b0100;
        end else if (a_inf) begin
            special_out = {sign, POS_INF[30:0]};
        end else if (b_inf || a_zero) begin
            special_out = {sign, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    always_comb begin
        qbit    = (rem >= {1'b0, mb});
        rem_sub = qbit ? (rem - {1'b0, mb}) : rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = UNPACK;
            end
            UNPACK: begin
                busy      = 1'b1;
                state_nxt = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (cnt == 5'(QBITS - 1)) state_nxt = ROUND;
            end
            ROUND: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? UNPACK : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Special cases still walk the full iteration so latency never varies
    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            flags <= '0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                a <= in1;
                b <= in2;
            end
            case (state)
                UNPACK: begin
                    rem <= {2'b01, fa};
                    q   <= '0;
                    cnt <= '0;
                end
                ITER: begin
                    q   <= {q[24:0], qbit};
                    rem <= rem_sub << 1;
                    cnt <= cnt + 5'd1;
                end
                ROUND: begin
                    if (special) begin
                        out   <= special_out;
                        flags <= special_flags;
                    end else begin
                        out   <= rp_out;
                        flags <= {2'b00, rp_of, rp_uf};
                    end
                end
                default: ;
            endcase
        end
    end

    fp32_round_pack u_round_pack (
        .sign      (sign),
        .e         (e),
        .q         (q),
        .sticky    (sticky),
        .out       (rp_out),
        .overflow  (rp_of),
        .underflow (rp_uf)
    );

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: directed table, handshake/reset sequences
// and random operands checked against an exact integer division model.
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in1, in2;
    logic        busy, done;
    logic [31:0] out;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    fdiv_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .flags (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [3:0]  f;
    } vec_t;

    vec_t vecs[15];

    task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive start for exactly one sampling edge; caller is at a negedge
    task applyStimulus(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        in1   = a;
        in2   = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task waitDone(output int lat);
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task runOp(input string name, input logic [31:0] a, input logic [31:0] b,
               input logic [31:0] exp_q, input logic [3:0] exp_f);
        int lat;
        applyStimulus(a, b);
        waitDone(lat);
        checkOutput({name, " latency"}, 32'(lat), 32'd29);
        checkOutput({name, " out"}, out, exp_q);
        checkOutput({name, " flags"}, 32'(flags), 32'(exp_f));
        @(negedge clk);
    endtask

    // Exact quotient via integer division, then round-to-nearest-even by
    // comparing twice the remainder with the divisor.
    function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [3:0] f);
        logic sign;
        logic [7:0] ea, eb;
        logic [22:0] fa, fb;
        logic an, ai, az, bn, bi, bz;
        longint unsigned ma, mb, num, m, rr;
        int ex;
        sign = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        an = (ea == 8'hFF) && (fa != 0); ai = (ea == 8'hFF) && (fa == 0); az = (ea == 0);
        bn = (eb == 8'hFF) && (fb != 0); bi = (eb == 8'hFF) && (fb == 0); bz = (eb == 0);
        f = 4'b0000;
        r = 32'h0;
        if (an || bn || (az && bz) || (ai && bi)) begin
            r = 32'h7FC00000;
            f = 4'b1000;
        end else if (bz && !ai) begin
            r = {sign, 31'h7F800000};
            f = 4'b0100;
        end else if (ai) begin
            r = {sign, 31'h7F800000};
        end else if (bi || az) begin
            r = {sign, 31'h0};
        end else begin
            ma = 64'h800000 + 64'(fa);
            mb = 64'h800000 + 64'(fb);
            ex = int'(ea) - int'(eb) + 127;
            if (ma >= mb) begin
                num = ma << 23;
            end else begin
                num = ma << 24;
                ex  = ex - 1;
            end
            m  = num / mb;
            rr = num % mb;
            if ((2 * rr > mb) || ((2 * rr == mb) && (m % 2 == 1))) m = m + 1;
            if (m == 64'h1000000) begin
                m  = m >> 1;
                ex = ex + 1;
            end
            if (ex >= 255) begin
                r = {sign, 31'h7F800000};
                f = 4'b0010;
            end else if (ex <= 0) begin
                r = {sign, 31'h0};
                f = 4'b0001;
            end else begin
                r = {sign, 8'(ex), 23'(m)};
            end
        end
    endfunction

    initial begin
        int lat;
        int seen;
        logic [31:0] ra, rb, mq;
        logic [3:0]  mf;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000};
        vecs[1]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000};
        vecs[3]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000};
        vecs[4]  = '{32'h40000000, 32'h00000000, 32'h7F800000, 4'b0100};
        vecs[5]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000};
        vecs[6]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000};
        vecs[7]  = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 4'b0010};
        vecs[8]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001};
        vecs[9]  = '{32'h00700000, 32'h40000000, 32'h00000000, 4'b0000};
        vecs[10] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000};
        vecs[11] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000};
        vecs[12] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000};
        vecs[13] = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
        vecs[14] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000};

        rst   = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset out", out, 32'h0);
        checkOutput("reset flags", 32'(flags), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed vectors");
        for (int i = 0; i < 15; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].f);
        end

        $display("[TB] start ignored while busy");
        applyStimulus(32'h40C00000, 32'h40000000);
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) checkOutput("busy after accept", 32'(busy), 32'd1);
            if (n == 5 || n == 20) begin
                start = 1'b1;
                in1   = 32'h3F800000;
                in2   = 32'h40400000;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        checkOutput("ignored-start latency", 32'(lat), 32'd29);
        checkOutput("ignored-start out", out, 32'h40400000);
        checkOutput("busy low in done cycle", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("idle after done", {30'd0, busy, done}, 32'd0);

        $display("[TB] back-to-back accept");
        applyStimulus(32'h40C00000, 32'h40000000);
        waitDone(lat);
        checkOutput("b2b first out", out, 32'h40400000);
        applyStimulus(32'h3F800000, 32'h40400000);
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 10) checkOutput("out held during op", out, 32'h40400000);
            if (done) begin
                lat = n;
                break;
            end
        end
        checkOutput("b2b second latency", 32'(lat), 32'd29);
        checkOutput("b2b second out", out, 32'h3EAAAAAB);
        @(negedge clk);

        $display("[TB] reset mid-operation");
        applyStimulus(32'h40C00000, 32'h40000000);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort out", out, 32'h0);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        checkOutput("no done after abort", 32'(seen), 32'd0);
        runOp("post-reset", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000);

        $display("[TB] random operands");
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) != 0) ra[30:23] = 8'($urandom_range(100, 154));
            if ($urandom_range(0, 3) != 0) rb[30:23] = 8'($urandom_range(100, 154));
            refDiv(ra, rb, mq, mf);
            runOp($sformatf("rand%0d %h/%h", i, ra, rb), ra, rb, mq, mf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
Iterative IEEE-754 single-precision divider, out = in1 / in2. It is the inverse operator alongside the FMul multiplier in the FP datapath and uses the same in1/in2/out operand naming. A start/busy/done handshake gives a fixed multi-cycle latency. Only one division is in flight at a time.

Parameters:
LATENCY, 28, cycles from the start-sampling edge to the done pulse (fixed; informational, must equal 1 + QBITS + 1).
QBITS, 26, quotient bits generated (1 integer + 23 fraction + guard + round).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only when busy=0
in1  in  32  dividend (fp32), captured on the accepted start edge
in2  in  32  divisor (fp32), captured on the accepted start edge
busy  out  1  high from the accepting edge until done
done  out  1  one-cycle pulse; out and flags valid
out  out  32  quotient, held until the next done
flags  out  4  {invalid, div_by_zero, overflow, underflow}, held with out

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, out=0, flags=0. Reset mid-operation aborts the division and produces no done.
- States: IDLE -> UNPACK (1 cycle) -> ITER (QBITS cycles) -> ROUND (1 cycle) -> DONE (1 cycle, done=1) -> IDLE.
- In IDLE or DONE with start=1: operands are latched and the state moves to UNPACK. Back-to-back accept in the DONE cycle is allowed. Start while busy=1 is ignored, and operands are not re-latched.
- Latency: an accepted start at edge k gives done=1 in the cycle after edge k+28. busy=1 during cycles k+1..k+28 and is 0 in the done cycle.
- Special cases complete with the same fixed latency.
- Unpack:
  - sign = s1 ^ s2.
  - Denormal inputs are treated as signed zero (DAZ).
  - ma = {1, frac1}, mb = {1, frac2}.
  - Exponent e = e1 - e2 + 127, held in a 10-bit signed register.
- Special cases (priority order):
  - NaN in, or 0/0, or inf/inf: out=0x7FC00000, invalid=1.
  - Finite nonzero / 0: out = sign·inf, div_by_zero=1.
  - inf/finite: out = sign·inf.
  - finite/inf or 0/nonzero: out = sign·0.
- ITER (restoring radix-2, one bit per cycle):
  - Remainder starts at ma.
  - Each cycle: if rem >= mb, then q bit = 1 and rem = rem - mb; then rem <<= 1.
  - Sticky = (final rem != 0).
- ROUND:
  - Normalize: if q[25]=0, shift q left 1 and set e = e - 1.
  - Keep 24 bits, then round-to-nearest-even using guard | round | sticky.
  - If mantissa carry-out (1.111..+ulp), shift right and set e = e + 1.
- Range:
  - e >= 255: out = sign·inf (0x7F800000 or 0xFF800000), overflow=1.
  - e <= 0: flush to sign·0, underflow=1 (FTZ; no denormal outputs).
- flags bits are independent. Non-special in-range results have flags=0.

Decomposition:
- Package fp32_pkg holds:
  - EXP_BIAS=127, QNAN=32'h7FC00000, POS_INF=32'h7F800000.
  - Field-extract widths (1/8/23).
  - The state enum {IDLE, UNPACK, ITER, ROUND, DONE}.
- One natural sub-module: fp32_round_pack. It is combinational: normalize, RNE, overflow/underflow and pack, with inputs {sign, e[9:0], q[25:0], sticky}. The FSM, iteration counter and remainder stay in fdiv_seq.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2), start 1 cycle → done exactly 28 cycles after accept, out=0x40400000, flags=0. Also 0xC0C00000 / 0x40000000 → 0xC0400000.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB (round-up via sticky). Also 0x3F800000 / 0x3F800000 → 0x3F800000.
- 0x40000000 / 0x00000000 → 0x7F800000, div_by_zero=1. 0/0 → 0x7FC00000, invalid=1. 0x7FC00000 / 0x3F800000 → 0x7FC00000, invalid=1.
- 0x7F000000 / 0x3F000000 → 0x7F800000, overflow=1. 0x00800000 / 0x40000000 → 0x00000000, underflow=1. Denormal 0x00700000 / 0x40000000 → 0x00000000.
- Handshake:
  - Start pulsed with new operands at cycles 5 and 20 after the first accept → ignored; first result unchanged.
  - Start held high in the done cycle → second op accepted, its done 28 cycles later.
- Reset asserted at cycle 10 of an operation → busy=0, done=0, out=0 next cycle. No done follows. A new start is then accepted normally.
